dac7611_scheduler: RTL and testbench

//   Shares one DAC7611 serial DAC between NREQ requesters. Arbitrates 12-bit code requests, then

---
 rtl/dac7611_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_dac7611_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac7611_scheduler.sv
// Arbitrates 12-bit code requests from NREQ producers and serialises the winner onto a DAC7611.
// Define DAC_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module dac7611_scheduler #(
    parameter int NREQ      = 4,
    parameter int HALF_PER  = 2,
    parameter int LD_SETUP  = 1,
    parameter int LD_WIDTH  = 2,
    parameter int CLR_WIDTH = 2,
    parameter int GAP       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_req,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [3:0]           dac_signals_15
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LDSET,
        S_LOAD,
        S_CLEAR,
        S_GAP
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] C_BIT_LAST   = CW'(2*HALF_PER - 1);
    localparam logic [CW-1:0] C_HALF       = CW'(HALF_PER);
    localparam logic [CW-1:0] C_LDSET_LAST = CW'(LD_SETUP - 1);
    localparam logic [CW-1:0] C_LOAD_LAST  = CW'(LD_WIDTH - 1);
    localparam logic [CW-1:0] C_CLR_LAST   = CW'(CLR_WIDTH - 1);
    localparam logic [CW-1:0] C_GAP_LAST   = CW'(GAP - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_bit;
    logic [11:0]     r_sh;
    logic [3:0]      r_pins;
    logic            r_busy;
    logic [2:0]      r_gid;
    logic            r_clr_pend;
`ifndef DAC_FIXED_PRIO_EN
    logic [2:0]      r_rr;
`endif

    logic            w_found;
    logic [2:0]      w_win;
    logic            w_take_clr;
    logic            w_accept;
    logic [11:0]     w_code;
    logic [CW-1:0]   w_cnt_nxt;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
`ifdef DAC_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found = 1'b1;
                w_win   = 3'(i);
            end
        end
`else
        // Scan from the pointer upwards, wrapping, and take the first valid requester.
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = 3'((int'(r_rr) + k) % NREQ);
            end
        end
`endif
    end

    assign w_take_clr = r_clr_pend | clr_req;
    assign w_accept   = (r_state == S_IDLE) && !w_take_clr && w_found;
    assign req_ready  = w_accept ? (NREQ'(1) << w_win) : '0;
    assign w_code     = req_data[12*w_win +: 12];
    assign w_cnt_nxt  = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_pins     <= 4'b1111;
            r_busy     <= 1'b0;
            r_gid      <= '0;
            r_clr_pend <= 1'b0;
`ifndef DAC_FIXED_PRIO_EN
            r_rr       <= '0;
`endif
        end else begin
            // Clears arriving while busy collapse into one pending request.
            if (clr_req && r_state != S_IDLE)
                r_clr_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_pins <= 4'b1111;
                    r_cnt  <= '0;
                    if (w_take_clr) begin
                        r_state    <= S_CLEAR;
                        r_clr_pend <= 1'b0;
                        r_busy     <= 1'b1;
                        r_pins     <= 4'b1110;
                    end else if (w_found) begin
                        r_state <= S_SHIFT;
                        r_sh    <= w_code;
                        r_bit   <= 4'd11;
                        r_gid   <= w_win;
                        r_busy  <= 1'b1;
                        r_pins  <= {1'b0, w_code[11], 2'b11};
`ifndef DAC_FIXED_PRIO_EN
                        r_rr    <= (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;
`endif
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == 4'd0) begin
                            r_state <= S_LDSET;
                            r_pins  <= 4'b1111;
                        end else begin
                            r_bit  <= r_bit - 4'd1;
                            r_sh   <= {r_sh[10:0], 1'b0};
                            r_pins <= {1'b0, r_sh[10], 2'b11};
                        end
                    end else begin
                        r_cnt  <= w_cnt_nxt;
                        r_pins <= {(w_cnt_nxt >= C_HALF), r_sh[11], 2'b11};
                    end
                end
                S_LDSET: begin
                    if (r_cnt == C_LDSET_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                        r_pins  <= 4'b1101;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == C_LOAD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                        r_pins  <= 4'b1111;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == C_CLR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                        r_pins  <= 4'b1111;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_GAP: begin
                    r_pins <= 4'b1111;
                    if (r_cnt == C_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pins  <= 4'b1111;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign grant_id       = r_gid;
    assign dac_signals_15 = r_pins;

endmodule

// File: tb/tb_dac7611_scheduler.sv
// Randomised and directed bench for dac7611_scheduler against a frame-offset reference model.
module tb_dac7611_scheduler;
    localparam int NREQ      = 4;
    localparam int FRAME_LEN = 52;
    localparam int CLR_LEN   = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [12*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 clr_req = 1'b0;
    logic                 busy;
    logic [2:0]           grant_id;
    logic [3:0]           dac_signals_15;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0 idle, 1 code frame, 2 clear; m_off counts cycles since the start edge.
    int          m_mode = 0;
    int          m_off  = 0;
    int          m_rr   = 0;
    int          m_gid  = 0;
    bit          m_pend = 0;
    logic [11:0] m_code = '0;

    dac7611_scheduler #(
        .NREQ(NREQ), .HALF_PER(2), .LD_SETUP(1), .LD_WIDTH(2), .CLR_WIDTH(2), .GAP(1)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .clr_req(clr_req), .busy(busy), .grant_id(grant_id),
        .dac_signals_15(dac_signals_15)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
`ifdef DAC_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic logic [3:0] m_pins();
        if (m_mode == 1) begin
            if (m_off < 48) return {((m_off % 4) >= 2), m_code[11 - m_off/4], 2'b11};
            if (m_off == 49 || m_off == 50) return 4'b1101;
            return 4'b1111;
        end
        if (m_mode == 2 && m_off < 2) return 4'b1110;
        return 4'b1111;
    endfunction

    function automatic logic m_busy();
        return m_mode != 0;
    endfunction

    function automatic logic [NREQ-1:0] m_ready();
        int w;
        if (m_mode != 0 || m_pend || clr_req) return '0;
        w = pick(req_valid, m_rr);
        if (w < 0) return '0;
        return NREQ'(1) << w;
    endfunction

    task automatic model_edge();
        int w;
        if (reset) begin
            m_mode = 0; m_off = 0; m_rr = 0; m_gid = 0; m_pend = 0;
        end else if (m_mode != 0) begin
            if (clr_req) m_pend = 1;
            m_off++;
            if ((m_mode == 1 && m_off == FRAME_LEN) || (m_mode == 2 && m_off == CLR_LEN)) m_mode = 0;
        end else if (m_pend || clr_req) begin
            m_mode = 2; m_off = 0; m_pend = 0;
        end else begin
            w = pick(req_valid, m_rr);
            if (w >= 0) begin
                m_mode = 1; m_off = 0; m_code = req_data[12*w +: 12];
                m_gid = w; m_rr = (w + 1) % NREQ;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        req_valid = '0; clr_req = 1'b0;
        for (int i = 0; i < 200 && m_mode != 0; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; clr_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int j = 0; j < 100; j++) begin
            #1;
            n_checks++;
            if ({dac_signals_15, busy, req_ready, grant_id} !== {4'b1111, 1'b0, 4'b0000, 3'd0})
                $display("FAIL reset_idle cyc%0d pins=%b busy=%b ready=%b gid=%0d want 1111/0/0000/0",
                         j, dac_signals_15, busy, req_ready, grant_id);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_single_a55();
        logic [11:0] bits = '0;
        int rises = 0, ld_first = -1, busy_low = -1;
        logic prev_clk = 1'b1;
        req_data[11:0] = 12'hA55; req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL a55_ready got %b want 0001", req_ready);
        else n_pass++;
        tick();
        req_valid = '0;
        for (int j = 0; j < 60; j++) begin
            #1;
            n_checks++;
            if ({dac_signals_15, busy, grant_id, req_ready} !== {m_pins(), m_busy(), 3'(m_gid), m_ready()})
                $display("FAIL a55_cyc%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", j, dac_signals_15, busy,
                         grant_id, req_ready, m_pins(), m_busy(), m_gid, m_ready());
            else n_pass++;
            if (!prev_clk && dac_signals_15[3]) begin bits = {bits[10:0], dac_signals_15[2]}; rises++; end
            prev_clk = dac_signals_15[3];
            if (ld_first < 0 && !dac_signals_15[1]) ld_first = j;
            if (busy_low < 0 && !busy) busy_low = j;
            tick();
        end
        n_checks++;
        if (bits !== 12'hA55 || rises != 12) $display("FAIL a55_sdi got %h (%0d rises) want a55 (12)", bits, rises);
        else n_pass++;
        n_checks++;
        if (ld_first != 49) $display("FAIL a55_ld_fall got %0d want 49", ld_first);
        else n_pass++;
        n_checks++;
        if (busy_low != 52) $display("FAIL a55_busy_low got %0d want 52", busy_low);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int k = 0;
        logic [NREQ-1:0] r;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[12*i +: 12] = 12'($urandom);
        req_valid = '1;
        for (int c = 0; c < 400 && k < 5; c++) begin
            #1;
            n_checks++;
            if ({dac_signals_15, busy, grant_id, req_ready} !== {m_pins(), m_busy(), 3'(m_gid), m_ready()})
                $display("FAIL rr_cyc%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c, dac_signals_15, busy,
                         grant_id, req_ready, m_pins(), m_busy(), m_gid, m_ready());
            else n_pass++;
            r = m_ready();
            tick();
            if (r != 0) begin
                #1;
                n_checks++;
                if (grant_id !== 3'(order[k])) $display("FAIL rr_order%0d got %0d want %0d", k, grant_id, order[k]);
                else n_pass++;
                k++;
                for (int i = 0; i < NREQ; i++) if (r[i]) req_data[12*i +: 12] = 12'($urandom);
            end
        end
        n_checks++;
        if (k != 5) $display("FAIL rr_budget got %0d grants want 5", k);
        else n_pass++;
    endtask

    task automatic test_clear_midframe();
        int falls = 0, clr_first = -1;
        logic prev_clr = 1'b1;
        wait_idle();
        req_data[11:0] = 12'hFFF; req_valid = 4'b0001;
        tick();
        req_valid = '0;
        for (int j = 0; j < 70; j++) begin
            clr_req = (j == 10 || j == 20);
            req_valid[1] = (j >= 30);
            #1;
            n_checks++;
            if ({dac_signals_15, busy, grant_id, req_ready} !== {m_pins(), m_busy(), 3'(m_gid), m_ready()})
                $display("FAIL clr_cyc%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", j, dac_signals_15, busy,
                         grant_id, req_ready, m_pins(), m_busy(), m_gid, m_ready());
            else n_pass++;
            if (prev_clr && !dac_signals_15[0]) begin falls++; if (clr_first < 0) clr_first = j; end
            prev_clr = dac_signals_15[0];
            if (j == 56) begin
                n_checks++;
                if (req_ready !== 4'b0010) $display("FAIL clr_next_ready got %b want 0010", req_ready);
                else n_pass++;
            end
            if (j == 57) begin
                n_checks++;
                if (grant_id !== 3'd1 || busy !== 1'b1) $display("FAIL clr_next_grant got %0d/%b want 1/1", grant_id, busy);
                else n_pass++;
            end
            tick();
        end
        clr_req = 1'b0;
        n_checks++;
        if (falls != 1) $display("FAIL clr_pulses got %0d want 1", falls);
        else n_pass++;
        n_checks++;
        if (clr_first != 53) $display("FAIL clr_start got %0d want 53", clr_first);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        wait_idle();
        req_data[24 +: 12] = 12'($urandom); req_valid = 4'b0100;
        tick();
        req_valid = '0;
        for (int j = 0; j <= 24; j++) begin
            if (j == 24) reset = 1'b1;
            #1;
            n_checks++;
            if ({dac_signals_15, busy, grant_id} !== {m_pins(), m_busy(), 3'(m_gid)})
                $display("FAIL rstmid_cyc%0d got %b/%b/%0d want %b/%b/%0d", j, dac_signals_15, busy,
                         grant_id, m_pins(), m_busy(), m_gid);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (dac_signals_15 !== 4'b1111 || busy !== 1'b0) $display("FAIL rstmid_abort got %b/%b want 1111/0", dac_signals_15, busy);
        else n_pass++;
        req_valid = '1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL rstmid_ready got %b want 0001", req_ready);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (grant_id !== 3'd0 || busy !== 1'b1) $display("FAIL rstmid_grant got %0d/%b want 0/1", grant_id, busy);
        else n_pass++;
        req_valid = '0;
    endtask

`ifdef DAC_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int k = 0;
        logic [NREQ-1:0] r;
        reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 4'b1010;
        for (int c = 0; c < 300 && k < 3; c++) begin
            #1;
            r = m_ready();
            tick();
            if (r != 0) begin
                #1;
                n_checks++;
                if (grant_id !== 3'd1) $display("FAIL fixed_grant%0d got %0d want 1", k, grant_id);
                else n_pass++;
                k++;
            end
        end
        n_checks++;
        if (k != 3) $display("FAIL fixed_budget got %0d grants want 3", k);
        else n_pass++;
        req_valid = '0;
    endtask
`endif

    task automatic test_random();
        logic [NREQ-1:0] r;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[12*i +: 12] = 12'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 299) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            clr_req = ($urandom_range(0, 149) == 0);
            reset = ($urandom_range(0, 999) == 0);
            #1;
            n_checks++;
            if ({dac_signals_15, busy, grant_id, req_ready} !== {m_pins(), m_busy(), 3'(m_gid), m_ready()})
                $display("FAIL rand_cyc%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c, dac_signals_15, busy,
                         grant_id, req_ready, m_pins(), m_busy(), m_gid, m_ready());
            else n_pass++;
            r = m_ready();
            tick();
            for (int i = 0; i < NREQ; i++) if (r[i]) req_valid[i] = 1'b0;
        end
        reset = 1'b0; clr_req = 1'b0; req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_a55();
        test_round_robin();
        test_clear_midframe();
        test_reset_midframe();
`ifdef DAC_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
